// File: rtl/modbus_uart_tx_frame.sv
// Modbus RTU / UART frame transmitter.
// Reads payload bytes from an external frame buffer by index and sends them as UART
// characters: start bit, DATA_BITS data bits (LSB first), optional parity, STOP_BITS stop
// bits. CRC-16 can be appended (low byte first). The RS-485 driver enable is raised
// DE_GUARD bit periods before the first start bit and dropped DE_GUARD bit periods after
// the last stop bit. The t3.5 line silence can be held before completion is reported.
//
// Ports:
//   clk       system clock, all logic on the rising edge
//   rst       synchronous active-low reset
//   iStart    start-frame request, only honoured while idle
//   iNtxB     payload byte count (CRC excluded), latched at start; zero is ignored
//   iDataIn   frame buffer read data for address oByteCnt (1-cycle read latency allowed)
//   oByteCnt  frame buffer read address
//   oTx       serial line, idle high
//   oTxEn     RS-485 driver enable
//   oBusy     frame in progress
//   oDone     one-cycle completion pulse
module modbus_uart_tx_frame #(
  parameter int unsigned FCLK      = 10000,
  parameter int unsigned BRATE     = 115200,
  parameter int unsigned BUF_WIDTH = 8,
  parameter int unsigned DATA_BITS = 8,
  parameter int unsigned PARITY    = 0,
  parameter int unsigned STOP_BITS = 1,
  parameter int unsigned CRC_ENA   = 1,
  parameter logic [15:0] CRC_POLY  = 16'hA001,
  parameter int unsigned T35_ENA   = 1,
  parameter int unsigned DE_GUARD  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 iStart,
  input  logic [BUF_WIDTH:0]   iNtxB,
  input  logic [7:0]           iDataIn,
  output logic [BUF_WIDTH-1:0] oByteCnt,
  output logic                 oTx,
  output logic                 oTxEn,
  output logic                 oBusy,
  output logic                 oDone
);

  localparam int unsigned DIV       = (FCLK * 1000) / BRATE;
  localparam int unsigned CHAR_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;
  localparam int unsigned T35_BITS  = (7 * CHAR_BITS + 1) / 2;
  localparam int unsigned MAX_LEN   = (DE_GUARD > T35_BITS) ? DE_GUARD :
                                      ((T35_BITS > 8) ? T35_BITS : 8);
  localparam int unsigned TMR_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned CNT_W     = $clog2(MAX_LEN + 1);
  localparam int unsigned IDX_W     = BUF_WIDTH + 2;

  localparam logic [7:0]       DATA_MASK = (DATA_BITS == 7) ? 8'h7F : 8'hFF;
  localparam logic             ODD_PAR   = (PARITY == 1);
  localparam logic [IDX_W-1:0] CRC_CHARS = (CRC_ENA != 0) ? IDX_W'(2) : '0;

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StLead  = 4'd1;
  localparam logic [3:0] StLoad  = 4'd2;
  localparam logic [3:0] StStart = 4'd3;
  localparam logic [3:0] StData  = 4'd4;
  localparam logic [3:0] StPar   = 4'd5;
  localparam logic [3:0] StStop  = 4'd6;
  localparam logic [3:0] StNext  = 4'd7;
  localparam logic [3:0] StLag   = 4'd8;
  localparam logic [3:0] StT35   = 4'd9;
  localparam logic [3:0] StDone  = 4'd10;

  // Where to go when an optional phase is configured away.
  localparam logic [3:0] AfterLag   = (T35_ENA != 0) ? StT35 : StDone;
  localparam logic [3:0] AfterStart = (DE_GUARD != 0) ? StLead : StLoad;
  localparam logic [3:0] AfterLast  = (DE_GUARD != 0) ? StLag : AfterLag;
  localparam logic [3:0] AfterData  = (PARITY != 0) ? StPar : StStop;

  logic [3:0]           state_q, state_d;
  logic [TMR_W-1:0]     tmr_q, tmr_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [BUF_WIDTH-1:0] addr_q, addr_d;
  logic [BUF_WIDTH:0]   n_q, n_d;
  logic [15:0]          crc_q, crc_d;
  logic [7:0]           sh_q, sh_d;
  logic                 par_q, par_d;

  // Reflected CRC-16 over one byte, all eight shift/xor steps unrolled.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
    end
    return r;
  endfunction

  logic                 tick;
  logic                 timed;
  logic [CNT_W-1:0]     last_cnt;
  logic [3:0]           nxt_timed;
  logic [IDX_W-1:0]     nxt_idx;
  logic [IDX_W-1:0]     n_ext;
  logic [IDX_W-1:0]     total;
  logic [BUF_WIDTH:0]   n_m1;
  logic [7:0]           char_sel;
  logic [7:0]           char_masked;

  assign tick    = (tmr_q == TMR_W'(DIV - 1));
  assign nxt_idx = idx_q + 1'b1;
  assign n_ext   = {1'b0, n_q};
  assign total   = n_ext + CRC_CHARS;
  assign n_m1    = n_q - 1'b1;

  always_comb begin
    char_sel = iDataIn;
    if (idx_q == n_ext) begin
      char_sel = crc_q[7:0];
    end else if (idx_q > n_ext) begin
      char_sel = crc_q[15:8];
    end
    char_masked = char_sel & DATA_MASK;
  end

  always_comb begin
    state_d   = state_q;
    tmr_d     = tmr_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    addr_d    = addr_q;
    n_d       = n_q;
    crc_d     = crc_q;
    sh_d      = sh_q;
    par_d     = par_q;
    timed     = 1'b0;
    last_cnt  = '0;
    nxt_timed = StIdle;

    unique case (state_q)
      StIdle: begin
        if (iStart && (iNtxB != '0)) begin
          n_d     = iNtxB;
          crc_d   = 16'hFFFF;
          idx_d   = '0;
          addr_d  = '0;
          tmr_d   = '0;
          cnt_d   = '0;
          state_d = AfterStart;
        end
      end
      StLead: begin
        timed     = 1'b1;
        last_cnt  = CNT_W'(DE_GUARD - 1);
        nxt_timed = StLoad;
      end
      StLoad: begin
        if (idx_q < n_ext) begin
          crc_d = crc_byte(crc_q, iDataIn);
        end
        sh_d  = char_masked;
        par_d = (^char_masked) ^ ODD_PAR;
        // Prefetch the next buffer address now so it is stable for a whole character
        // before the next load; it parks on the last payload byte during the CRC bytes.
        if (nxt_idx < n_ext) begin
          addr_d = nxt_idx[BUF_WIDTH-1:0];
        end else begin
          addr_d = n_m1[BUF_WIDTH-1:0];
        end
        tmr_d   = '0;
        cnt_d   = '0;
        state_d = StStart;
      end
      StStart: begin
        timed     = 1'b1;
        last_cnt  = '0;
        nxt_timed = StData;
      end
      StData: begin
        timed     = 1'b1;
        last_cnt  = CNT_W'(DATA_BITS - 1);
        nxt_timed = AfterData;
        if (tick) begin
          sh_d = sh_q >> 1;
        end
      end
      StPar: begin
        timed     = 1'b1;
        last_cnt  = '0;
        nxt_timed = StStop;
      end
      StStop: begin
        timed     = 1'b1;
        last_cnt  = CNT_W'(STOP_BITS - 1);
        nxt_timed = StNext;
      end
      StNext: begin
        idx_d   = nxt_idx;
        tmr_d   = '0;
        cnt_d   = '0;
        state_d = (nxt_idx < total) ? StLoad : AfterLast;
      end
      StLag: begin
        timed     = 1'b1;
        last_cnt  = CNT_W'(DE_GUARD - 1);
        nxt_timed = AfterLag;
      end
      StT35: begin
        timed     = 1'b1;
        last_cnt  = CNT_W'(T35_BITS - 1);
        nxt_timed = StDone;
      end
      StDone: begin
        idx_d   = '0;
        addr_d  = '0;
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Shared bit-period timing for every state that lasts a whole number of bit periods.
    if (timed) begin
      if (tick) begin
        tmr_d = '0;
        if (cnt_q == last_cnt) begin
          cnt_d   = '0;
          state_d = nxt_timed;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end else begin
        tmr_d = tmr_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= StIdle;
      tmr_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      addr_q  <= '0;
      n_q     <= '0;
      crc_q   <= 16'hFFFF;
      sh_q    <= '0;
      par_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      addr_q  <= addr_d;
      n_q     <= n_d;
      crc_q   <= crc_d;
      sh_q    <= sh_d;
      par_q   <= par_d;
    end
  end

  always_comb begin
    oTx = 1'b1;
    unique case (state_q)
      StStart: oTx = 1'b0;
      StData:  oTx = sh_q[0];
      StPar:   oTx = par_q;
      default: oTx = 1'b1;
    endcase
  end

  assign oTxEn    = (state_q != StIdle) && (state_q != StT35) && (state_q != StDone);
  assign oBusy    = (state_q != StIdle) && (state_q != StDone);
  assign oDone    = (state_q == StDone);
  assign oByteCnt = addr_q;

endmodule

// File: doc/modbus_uart_tx_frame.md
Name: modbus_uart_tx_frame

Overview:
- Parametrised next-generation UART/Modbus RTU frame transmitter.
- Fetches payload bytes from an external frame buffer by index, serialises them with configurable data width, parity and stop bits, and optionally appends CRC-16.
- Drives an RS-485 driver-enable with lead/lag guard time.
- Enforces the Modbus t3.5 inter-frame silence before reporting done. Sits between the Modbus slave response builder/buffer and the pin.

Parameters:
- FCLK, 10000, system clock frequency in kHz.
- BRATE, 115200, baud rate; DIV = FCLK*1000/BRATE clocks per bit (integer truncation).
- BUF_WIDTH, 8, frame buffer address width; max payload 2**BUF_WIDTH bytes.
- DATA_BITS, 8, data bits per character, legal 7 or 8.
- PARITY, 0, 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1, legal 1 or 2.
- CRC_ENA, 1, 1 = append CRC-16 (low byte first) after the payload.
- CRC_POLY, 16'hA001, reflected CRC polynomial; CRC init 16'hFFFF.
- T35_ENA, 1, 1 = hold t3.5 silence after the last stop bit before done.
- DE_GUARD, 1, driver-enable lead and lag time in bit periods.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- iStart  in  1  start-frame request, sampled in IDLE only.
- iNtxB  in  BUF_WIDTH+1  payload byte count, excluding CRC; latched at start.
- iDataIn  in  8  buffer read data for address oByteCnt; bits above DATA_BITS are ignored.
- oByteCnt  out  BUF_WIDTH  buffer read address.
- oTx  out  1  serial line, idle high.
- oTxEn  out  1  RS-485 driver enable.
- oBusy  out  1  high from the cycle after an accepted start until done.
- oDone  out  1  one-cycle pulse at frame completion.

Behaviour:
- Reset (rst=0 at a clock edge): next cycle oTx=1, oTxEn=0, oBusy=0, oDone=0, oByteCnt=0, state=IDLE, all counters 0, crc=16'hFFFF. This applies mid-frame as well, with no partial completion and no oDone.
- Bit timer: every serial element (start, data, parity, stop) lasts exactly DIV clocks.
- CHAR_BITS = 1 + DATA_BITS + (PARITY!=0) + STOP_BITS.
- T35 silence = ceil(7*CHAR_BITS/2) bit periods.
- Start acceptance:
  - IDLE with iStart=1 and iNtxB!=0: latch N=iNtxB, go to LEAD.
  - iStart with iNtxB=0: ignored, no activity.
  - iStart while busy: ignored.
- FSM states: IDLE, LEAD, LOAD, START, DATA, PAR, STOP, NEXT, LAG, T35, DONE.
- LEAD: oTxEn=1, oTx=1 for DE_GUARD bit periods, then LOAD.
- LOAD: one cycle. The character comes from one of three sources:
  - byte index < N: iDataIn (oByteCnt has been stable ≥2 cycles, allowing synchronous-RAM latency of 1); crc updated with the byte, 8 reflected shift/xor steps, combinationally unrolled.
  - index == N: crc[7:0].
  - index == N+1: crc[15:8].
  - CRC bytes never update crc. With DATA_BITS=7 the CRC is still computed over the 8-bit iDataIn, and only the low 7 bits of each CRC byte are sent.
- START: oTx=0, one bit period.
- DATA: LSB first, DATA_BITS periods.
- PAR (only when PARITY!=0): even parity makes the total count of ones over data+parity even; odd parity makes it odd.
- STOP: oTx=1 for STOP_BITS periods.
- NEXT: one cycle.
  - If more characters remain: index+1, oByteCnt = min(index+1, N-1) held during CRC bytes, go to LOAD.
  - Otherwise go to LAG.
- Total characters per frame = N + 2*CRC_ENA.
- LAG: oTx=1, oTxEn held 1 for DE_GUARD periods, then oTxEn=0.
- T35: silence timer, skipped if T35_ENA=0.
- DONE: oDone=1 for one cycle, oBusy=0, oByteCnt=0, return to IDLE. iStart in the DONE cycle is ignored.
- oByteCnt wraps only through N ≤ 2**BUF_WIDTH; N = 2**BUF_WIDTH is legal and sends addresses 0..2**BUF_WIDTH-1.

Test Plan:
1. 8N1, CRC_ENA=1, DIV=86, payload 01 03 00 00 00 01 -> 8 characters on oTx: 01 03 00 00 00 01 84 0A; each bit exactly 86 clocks; oDone is one pulse (DE_GUARD+80+35+DE_GUARD)*86 clocks after start.
2. PARITY=2, STOP_BITS=2, CRC_ENA=0, byte 0x07 -> start, 1,1,1,0,0,0,0,0, parity 1, stop, stop; T35 silence is 42 bit periods (CHAR_BITS=12).
3. PARITY=1, DATA_BITS=7, byte 0x55 -> 7 data bits 1,0,1,0,1,0,1, parity 1 (four ones in data, odd total required).
4. iNtxB=0 with iStart=1 -> oBusy, oTxEn and oDone stay 0; oTx stays 1. A second iStart pulse mid-frame -> no effect on the frame.
5. rst=0 during the 3rd data bit of byte 2 -> oTx=1 and oTxEn=0 on the next cycle; a subsequent frame CRC restarts from FFFF (payload 01 03 00 00 00 01 again yields 84 0A).
6. N=1, CRC_ENA=0, T35_ENA=0, payload 0xA5 -> oByteCnt stays 0 throughout; oDone asserts 2*DE_GUARD+10 bit periods after start, plus fixed cycles.
